cell_truth_sequencer: RTL and testbench
=======================================

Name: cell_truth_sequencer

Overview:
- Self-checking sequencer for one combinational library cell with up to 6 inputs.
- On START it drives every input vector 0..2^N_IN-1 onto the cell.
- For each vector it waits a programmable settle time, samples the cell output and compares it with the expected truth table.
- Reports the mismatch count, the first failing vector, DONE and PASS. It sits beside the cell model in gate-level regression and bring-up benches.

Parameters:
- N_IN, 2, number of cell inputs driven; legal 1..6.
- SETTLE, 2, cycles STIM is held before the output is sampled; legal 1..255.
- EXPECT, 64'h8, truth table; bit v is the expected output for vector v; only bits [2^N_IN-1:0] are used; default is AND2.
- ERR_W, N_IN+1, width of the error counter; derived, do not override.

Ports:
- CK  input  1  clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- START  input  1  level-sampled; starts a sweep when in IDLE.
- ABORT  input  1  cancels a sweep in progress.
- DUT_Z  input  1  cell output under test.
- STIM  output  N_IN  input vector driven to the cell.
- BUSY  output  1  high in WAIT and CHECK.
- DONE  output  1  one-cycle pulse when a sweep completes.
- PASS  output  1  sweep finished with zero mismatches; held.
- ERR_CNT  output  ERR_W  mismatch count of the last or current sweep.
- FIRST_FAIL  output  N_IN  first vector that mismatched.
- FIRST_FAIL_VLD  output  1  FIRST_FAIL is valid.

Behaviour:
- Reset: RST high asynchronously clears all state. State=IDLE; STIM=0; BUSY=0; DONE=0; PASS=0; ERR_CNT=0; FIRST_FAIL=0; FIRST_FAIL_VLD=0; vec=0; cnt=0.
- Reset mid-sweep: the sweep is abandoned with no DONE pulse.
- States: IDLE, WAIT, CHECK, FIN.
- IDLE:
  - STIM=0.
  - START=1 and ABORT=0 -> WAIT. On that edge: vec=0, cnt=0, ERR_CNT=0, FIRST_FAIL_VLD=0, FIRST_FAIL=0, PASS=0.
- WAIT:
  - STIM=vec, held stable.
  - cnt==SETTLE-1 -> CHECK; otherwise cnt++.
  - WAIT therefore lasts exactly SETTLE cycles.
- CHECK (1 cycle):
  - DUT_Z is sampled on the exiting edge and compared with EXPECT[vec].
  - Mismatch: ERR_CNT++ (cannot overflow, since ERR_W holds 2^N_IN).
  - Mismatch while FIRST_FAIL_VLD=0: FIRST_FAIL=vec and FIRST_FAIL_VLD=1.
  - vec==2^N_IN-1 -> FIN. Otherwise vec++, cnt=0 -> WAIT.
  - vec never wraps within a sweep.
- FIN (1 cycle):
  - DONE=1.
  - PASS is registered on the entry edge as (final ERR_CNT==0) and includes the last vector's result.
  - Next state is IDLE.
  - PASS, ERR_CNT and FIRST_FAIL* are held until the next accepted START or RST.
- Latency: SETTLE+1 cycles per vector. DONE is high in cycle 2^N_IN*(SETTLE+1)+1, counting the START-sampling edge as cycle 0's end.
- START while BUSY or in FIN: ignored, with no restart.
- ABORT in WAIT or CHECK: -> IDLE next edge.
  - STIM=0 and no DONE.
  - PASS stays 0.
  - ERR_CNT and FIRST_FAIL* are retained, frozen at their pre-abort values. A mismatch in an aborted CHECK cycle is not counted.
- ABORT in FIN: ignored; the DONE pulse still occurs.
- START and ABORT both high in IDLE: ABORT wins; stay IDLE, outputs unchanged.
- BUSY is combinational from the state register (WAIT or CHECK). All other outputs are registered.
- DUT_Z X or Z during CHECK: treated as a mismatch in simulation, i.e. the compare is a case-inequality.

Test Plan:
1. N_IN=2, SETTLE=2, EXPECT=8, DUT=AND2 model, pulse START -> STIM steps 0,1,2,3 holding each for 3 cycles; DONE single pulse 13 cycles after START edge; PASS=1; ERR_CNT=0; FIRST_FAIL_VLD=0.
2. Same setup, DUT=NAND2 model -> DONE at 13; PASS=0; ERR_CNT=4; FIRST_FAIL=0; FIRST_FAIL_VLD=1.
3. N_IN=3, SETTLE=1, EXPECT=8'h01, DUT=NOR3 model with bit 5 forced to 1 -> DONE 17 cycles after START; ERR_CNT=1; FIRST_FAIL=5; PASS=0.
4. Scenario 1 setup, ABORT asserted during the CHECK of vec=2 -> IDLE next edge; STIM=0; no DONE; PASS=0; ERR_CNT=0; a START re-asserted during BUSY earlier had no effect.
5. RST pulsed asynchronously mid-WAIT (between clock edges) -> all outputs 0 immediately; a subsequent START gives a full clean sweep matching scenario 1.
6. START and ABORT high together in IDLE -> remains IDLE; BUSY=0; prior PASS/ERR_CNT unchanged; START alone next cycle begins the sweep.

Source files
------------

// File: rtl/cell_truth_sequencer_if.sv
// ---------------------------------------------------------------------------
// cell_truth_sequencer_if
//   Signal bundle between a truth-table sequencer and the bench or cell it
//   drives. The sequencer is the slave (it receives START/ABORT and the
//   cell output). The bench side is the master.
//
//   START          level request to begin a sweep
//   ABORT          cancel a sweep in progress
//   DUT_Z          output of the cell under test
//   STIM           input vector applied to the cell
//   BUSY           sweep in progress (WAIT or CHECK)
//   DONE           one-cycle completion pulse
//   PASS           last sweep completed with no mismatches
//   ERR_CNT        mismatch count of the last or current sweep
//   FIRST_FAIL     first mismatching vector
//   FIRST_FAIL_VLD FIRST_FAIL holds a real vector
// ---------------------------------------------------------------------------
interface cell_truth_sequencer_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = N_IN + 1
);
  logic             START;
  logic             ABORT;
  logic             DUT_Z;
  logic [N_IN-1:0]  STIM;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [ERR_W-1:0] ERR_CNT;
  logic [N_IN-1:0]  FIRST_FAIL;
  logic             FIRST_FAIL_VLD;

  modport master (
    output START, ABORT, DUT_Z,
    input  STIM, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL, FIRST_FAIL_VLD
  );

  modport slave (
    input  START, ABORT, DUT_Z,
    output STIM, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL, FIRST_FAIL_VLD
  );
endinterface

// File: rtl/cell_truth_sequencer.sv
// ---------------------------------------------------------------------------
// cell_truth_sequencer
//   Exhaustively sweeps every input vector 0..2^N_IN-1 of a combinational
//   cell. Each vector is held SETTLE cycles, then the cell output is sampled
//   during a one-cycle CHECK and compared against EXPECT[vec]. Reports the
//   mismatch count, first failing vector, a DONE pulse and a held PASS.
//
// Parameters
//   N_IN    cell inputs driven (1..6)
//   SETTLE  hold cycles before sampling (1..255)
//   EXPECT  truth table, bit v = expected output for vector v
//   ERR_W   error counter width, derived from N_IN
//
// Ports
//   CK   clock, rising edge
//   RST  asynchronous reset, active high
//   bus  slave view of cell_truth_sequencer_if
// ---------------------------------------------------------------------------
module cell_truth_sequencer #(
  parameter int          N_IN   = 2,
  parameter int          SETTLE = 2,
  parameter logic [63:0] EXPECT = 64'h8,
  parameter int          ERR_W  = N_IN + 1
) (
  input  logic                   CK,
  input  logic                   RST,
  cell_truth_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_FIN} state_t;

  localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0]  VEC_ONE  = N_IN'(1);
  localparam logic [7:0]       CNT_LAST = 8'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_t           r_state, w_state;
  logic [N_IN-1:0]  r_vec,   w_vec;
  logic [7:0]       r_cnt,   w_cnt;
  logic [N_IN-1:0]  r_stim,  w_stim;
  logic             r_done,  w_done;
  logic             r_pass,  w_pass;
  logic [ERR_W-1:0] r_err,   w_err;
  logic [N_IN-1:0]  r_ff,    w_ff;
  logic             r_ffv,   w_ffv;

  logic [5:0]       w_idx;
  logic             w_miss;

  assign w_idx  = 6'(r_vec);
  // Case-inequality so an X/Z cell output counts as a mismatch in simulation.
  assign w_miss = (bus.DUT_Z !== EXPECT[w_idx]);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_stim  <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_ff    <= '0;
      r_ffv   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_vec   <= w_vec;
      r_cnt   <= w_cnt;
      r_stim  <= w_stim;
      r_done  <= w_done;
      r_pass  <= w_pass;
      r_err   <= w_err;
      r_ff    <= w_ff;
      r_ffv   <= w_ffv;
    end
  end

  always_comb begin
    w_state = r_state;
    w_vec   = r_vec;
    w_cnt   = r_cnt;
    w_stim  = r_stim;
    w_done  = 1'b0;
    w_pass  = r_pass;
    w_err   = r_err;
    w_ff    = r_ff;
    w_ffv   = r_ffv;

    unique case (r_state)
      S_IDLE: begin
        w_stim = '0;
        // ABORT has priority over START so a simultaneous pair is a no-op.
        if (bus.START && !bus.ABORT) begin
          w_state = S_WAIT;
          w_vec   = '0;
          w_cnt   = '0;
          w_err   = '0;
          w_ff    = '0;
          w_ffv   = 1'b0;
          w_pass  = 1'b0;
        end
      end

      S_WAIT: begin
        if (bus.ABORT) begin
          w_state = S_IDLE;
          w_stim  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state = S_CHECK;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end

      S_CHECK: begin
        // An aborted CHECK discards its compare; counters stay frozen.
        if (bus.ABORT) begin
          w_state = S_IDLE;
          w_stim  = '0;
        end else begin
          if (w_miss) begin
            w_err = r_err + ERR_ONE;
            if (!r_ffv) begin
              w_ff  = r_vec;
              w_ffv = 1'b1;
            end
          end
          if (r_vec == VEC_LAST) begin
            // PASS uses the updated count so the last vector is included.
            w_state = S_FIN;
            w_done  = 1'b1;
            w_pass  = (w_err == '0);
          end else begin
            w_state = S_WAIT;
            w_vec   = r_vec + VEC_ONE;
            w_cnt   = '0;
            w_stim  = r_vec + VEC_ONE;
          end
        end
      end

      S_FIN: begin
        // ABORT and START are both ignored here; the DONE pulse is already out.
        w_state = S_IDLE;
        w_stim  = '0;
      end

      default: begin
        w_state = S_IDLE;
        w_stim  = '0;
      end
    endcase
  end

  assign bus.STIM           = r_stim;
  assign bus.BUSY           = (r_state == S_WAIT) || (r_state == S_CHECK);
  assign bus.DONE           = r_done;
  assign bus.PASS           = r_pass;
  assign bus.ERR_CNT        = r_err;
  assign bus.FIRST_FAIL     = r_ff;
  assign bus.FIRST_FAIL_VLD = r_ffv;

endmodule

// File: tb/tb_cell_truth_sequencer.sv
module tb_cell_truth_sequencer;

  typedef struct {
    logic        pass;
    logic [31:0] err;
    logic [31:0] ff;
    logic        ffv;
    int          lat;
  } exp_t;

  logic CK  = 1'b0;
  logic RST = 1'b0;
  logic nand_mode = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];

  always #5 CK = ~CK;

  cell_truth_sequencer_if #(.N_IN(2)) b2();
  cell_truth_sequencer_if #(.N_IN(3)) b3();

  cell_truth_sequencer #(.N_IN(2), .SETTLE(2), .EXPECT(64'h8)) u_dut2 (
    .CK(CK), .RST(RST), .bus(b2)
  );
  cell_truth_sequencer #(.N_IN(3), .SETTLE(1), .EXPECT(64'h01)) u_dut3 (
    .CK(CK), .RST(RST), .bus(b3)
  );

  // Cell models: AND2 / NAND2 and a NOR3 with a stuck-high output on vector 5.
  assign b2.DUT_Z = nand_mode ? ~&b2.STIM : &b2.STIM;
  assign b3.DUT_Z = (b3.STIM == 3'd5) ? 1'b1 : ~|b3.STIM;

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CK);
    @(negedge CK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input bit s3, input int f);
    logic [31:0] v;
    v = '0;
    case (f)
      0: v = s3 ? 32'(b3.STIM)           : 32'(b2.STIM);
      1: v = s3 ? 32'(b3.BUSY)           : 32'(b2.BUSY);
      2: v = s3 ? 32'(b3.DONE)           : 32'(b2.DONE);
      3: v = s3 ? 32'(b3.PASS)           : 32'(b2.PASS);
      4: v = s3 ? 32'(b3.ERR_CNT)        : 32'(b2.ERR_CNT);
      5: v = s3 ? 32'(b3.FIRST_FAIL)     : 32'(b2.FIRST_FAIL);
      6: v = s3 ? 32'(b3.FIRST_FAIL_VLD) : 32'(b2.FIRST_FAIL_VLD);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Full sweep: push expectation, pulse START, follow STIM each cycle,
  // pop and compare when DONE appears.
  task automatic do_sweep(input bit s3, input exp_t e);
    int   c;
    int   spc;
    bit   got;
    exp_t ex;
    spc = s3 ? 2 : 3;
    sb.push_back(e);
    if (s3) b3.START = 1'b1; else b2.START = 1'b1;
    tick();
    b2.START = 1'b0;
    b3.START = 1'b0;
    c   = 1;
    got = 0;
    while (!got && c < 100) begin
      if (rd(s3, 2) === 32'd1) begin
        got = 1;
      end else begin
        chk("sweep_stim", rd(s3, 0), 32'((c - 1) / spc));
        chk("sweep_busy", rd(s3, 1), 32'd1);
        tick();
        c++;
      end
    end
    ex = sb.pop_front();
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("done_latency", 32'(c),   32'(ex.lat));
      chk("sweep_pass",   rd(s3, 3), 32'(ex.pass));
      chk("sweep_err",    rd(s3, 4), ex.err);
      chk("sweep_ff",     rd(s3, 5), ex.ff);
      chk("sweep_ffv",    rd(s3, 6), 32'(ex.ffv));
    end
    tick();
    chk("done_single",  rd(s3, 2), 32'd0);
    chk("post_busy",    rd(s3, 1), 32'd0);
    chk("post_stim",    rd(s3, 0), 32'd0);
    chk("pass_held",    rd(s3, 3), 32'(ex.pass));
    chk("err_held",     rd(s3, 4), ex.err);
  endtask

  // Start on dut2, re-raise START while busy, ABORT in the CHECK of vec 2.
  task automatic abort_run(input logic [31:0] exp_err, input logic exp_ffv);
    int seen;
    b2.START = 1'b1;
    tick();
    b2.START = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) b2.START = 1'b1;
      if (c == 3) b2.START = 1'b0;
      chk("abort_stim", rd(0, 0), 32'((c - 1) / 3));
      tick();
    end
    chk("abort_pre_stim", rd(0, 0), 32'd2);
    chk("abort_pre_busy", rd(0, 1), 32'd1);
    b2.ABORT = 1'b1;
    tick();
    b2.ABORT = 1'b0;
    chk("abort_busy", rd(0, 1), 32'd0);
    chk("abort_stim0", rd(0, 0), 32'd0);
    chk("abort_done", rd(0, 2), 32'd0);
    chk("abort_pass", rd(0, 3), 32'd0);
    chk("abort_err",  rd(0, 4), exp_err);
    chk("abort_ff",   rd(0, 5), 32'd0);
    chk("abort_ffv",  rd(0, 6), 32'(exp_ffv));
    seen = 0;
    repeat (20) begin
      if (b2.DONE !== 1'b0) seen++;
      tick();
    end
    chk("abort_no_done", 32'(seen), 32'd0);
  endtask

  initial begin
    string nm[7];
    nm = '{"rst_stim", "rst_busy", "rst_done", "rst_pass", "rst_err", "rst_ff", "rst_ffv"};
    b2.START = 1'b0; b2.ABORT = 1'b0;
    b3.START = 1'b0; b3.ABORT = 1'b0;

    #1 RST = 1'b1;
    #11;
    for (int f = 0; f < 7; f++) chk(nm[f], rd(0, f), 32'd0);
    for (int f = 0; f < 7; f++) chk(nm[f], rd(1, f), 32'd0);
    @(negedge CK);
    RST = 1'b0;
    tick();

    // AND2 model against AND2 table: clean sweep.
    nand_mode = 1'b0;
    do_sweep(0, '{pass: 1'b1, err: 32'd0, ff: 32'd0, ffv: 1'b0, lat: 13});

    // NAND2 model: every vector mismatches.
    nand_mode = 1'b1;
    do_sweep(0, '{pass: 1'b0, err: 32'd4, ff: 32'd0, ffv: 1'b1, lat: 13});

    // START and ABORT together in IDLE: nothing happens, results held.
    b2.START = 1'b1;
    b2.ABORT = 1'b1;
    tick();
    b2.START = 1'b0;
    b2.ABORT = 1'b0;
    chk("both_busy", rd(0, 1), 32'd0);
    chk("both_stim", rd(0, 0), 32'd0);
    chk("both_pass", rd(0, 3), 32'd0);
    chk("both_err",  rd(0, 4), 32'd4);
    chk("both_ffv",  rd(0, 6), 32'd1);
    nand_mode = 1'b0;
    do_sweep(0, '{pass: 1'b1, err: 32'd0, ff: 32'd0, ffv: 1'b0, lat: 13});

    // ABORT in CHECK of vec 2, clean cell, then failing cell.
    abort_run(32'd0, 1'b0);
    nand_mode = 1'b1;
    abort_run(32'd2, 1'b1);

    // Asynchronous reset in the middle of a WAIT.
    b2.START = 1'b1;
    tick();
    b2.START = 1'b0;
    repeat (4) tick();
    chk("pre_rst_stim", rd(0, 0), 32'd1);
    chk("pre_rst_err",  rd(0, 4), 32'd1);
    chk("pre_rst_busy", rd(0, 1), 32'd1);
    #2 RST = 1'b1;
    #1;
    for (int f = 0; f < 7; f++) chk(nm[f], rd(0, f), 32'd0);
    @(negedge CK);
    RST = 1'b0;
    nand_mode = 1'b0;
    tick();
    do_sweep(0, '{pass: 1'b1, err: 32'd0, ff: 32'd0, ffv: 1'b0, lat: 13});

    // Three-input cell with a single bad vector.
    do_sweep(1, '{pass: 1'b0, err: 32'd1, ff: 32'd5, ffv: 1'b1, lat: 17});

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
